// File: rtl/issue_rat_redeemer_pkg.sv
// rtl/issue_rat_redeemer_pkg.sv - shared widths, depth and entry type for the RAT redeemer
package issue_rat_redeemer_pkg;

    localparam int PRF_W = 6;
    localparam int FGR_W = 4;
    localparam int DEPTH = 16;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [PRF_W-1:0] prf;
        logic [FGR_W-1:0] fgr;
        logic             spec;
        logic             live;
    } rat_entry_t;

    // Pointers carry a wrap bit above the index so full and empty are distinguishable.
    function automatic logic ptr_full(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
        return (wr[IDX_W-1:0] == rd[IDX_W-1:0]) && (wr[IDX_W] != rd[IDX_W]);
    endfunction

endpackage

// File: rtl/issue_rat_redeemer_outreg.sv
// rtl/issue_rat_redeemer_outreg.sv - single-entry valid/ready register feeding the freelist
module issue_rat_redeemer_outreg
    import issue_rat_redeemer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [PRF_W-1:0] i_data,
    input  logic             i_ready,
    output logic             o_can_load,
    output logic             o_valid,
    output logic [PRF_W-1:0] o_data
);

    logic             valid_q, valid_d;
    logic [PRF_W-1:0] data_q,  data_d;

    assign o_can_load = !valid_q || i_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/issue_rat_redeemer.sv
// rtl/issue_rat_redeemer.sv - in-order queue of displaced PRFs redeemed once their FGR commits
// Optional ISSUE_RAT_REDEEMER_ENQ_BYPASS_EN lets a full queue accept when its head pops.
module issue_rat_redeemer
    import issue_rat_redeemer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [PRF_W-1:0] i_enq_prf,
    input  logic [FGR_W-1:0] i_enq_fgr,
    input  logic             i_enq_speculative,
    input  logic             i_enq_valid,
    output logic             o_enq_ready,
    input  logic [FGR_W-1:0] i_commit_fgr,
    input  logic             i_commit_valid,
    input  logic [FGR_W-1:0] i_abandon_fgr,
    input  logic             i_abandon_valid,
    input  logic             i_retire_valid,
    output logic             o_retire_ready,
    output logic [PRF_W-1:0] o_redeemed_prf,
    output logic             o_redeemed_valid,
    input  logic             i_redeemed_ready
);

    rat_entry_t       entries_q [DEPTH];
    rat_entry_t       entries_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic             empty, full;
    rat_entry_t       head;
    logic             head_drop, retire_fire, pop, enq_fire, out_can_load;
    logic [IDX_W-1:0] wr_idx;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = ptr_full(wr_ptr_q, rd_ptr_q);
    assign head   = entries_q[rd_ptr_q[IDX_W-1:0]];

    // Killed entries drain from the head on their own; they never reach the freelist.
    assign head_drop      = !empty && !head.live;
    assign o_retire_ready = !empty && head.live && !head.spec && out_can_load;
    assign retire_fire    = i_retire_valid && o_retire_ready;
    assign pop            = head_drop || retire_fire;

`ifdef ISSUE_RAT_REDEEMER_ENQ_BYPASS_EN
    assign o_enq_ready = !full || pop;
`else
    assign o_enq_ready = !full;
`endif

    assign enq_fire = i_enq_valid && o_enq_ready;

    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_commit_valid && entries_q[i].live && (entries_q[i].fgr == i_commit_fgr)) begin
                entries_d[i].spec = 1'b0;
            end
            // Applied after commit so a simultaneous abandon of the same FGR kills the entry.
            if (i_abandon_valid && (entries_q[i].fgr == i_abandon_fgr)) begin
                entries_d[i].live = 1'b0;
            end
        end
        if (enq_fire) begin
            entries_d[wr_idx].prf  = i_enq_prf;
            entries_d[wr_idx].fgr  = i_enq_fgr;
            entries_d[wr_idx].spec = i_enq_speculative &&
                                     !(i_commit_valid && (i_commit_fgr == i_enq_fgr));
            entries_d[wr_idx].live = !(i_abandon_valid && (i_abandon_fgr == i_enq_fgr));
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    issue_rat_redeemer_outreg u_outreg (
        .clk        (clk),
        .reset      (reset),
        .i_load     (retire_fire),
        .i_data     (head.prf),
        .i_ready    (i_redeemed_ready),
        .o_can_load (out_can_load),
        .o_valid    (o_redeemed_valid),
        .o_data     (o_redeemed_prf)
    );

endmodule

// File: tb/tb_issue_rat_redeemer.sv
// tb/tb_issue_rat_redeemer.sv - directed and random checks of issue_rat_redeemer against a queue model
module tb_issue_rat_redeemer;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] i_enq_prf;
    logic [3:0] i_enq_fgr;
    logic       i_enq_speculative, i_enq_valid, o_enq_ready;
    logic [3:0] i_commit_fgr, i_abandon_fgr;
    logic       i_commit_valid, i_abandon_valid;
    logic       i_retire_valid, o_retire_ready;
    logic [5:0] o_redeemed_prf;
    logic       o_redeemed_valid, i_redeemed_ready;

    issue_rat_redeemer dut (
        .clk               (clk),
        .reset             (reset),
        .i_enq_prf         (i_enq_prf),
        .i_enq_fgr         (i_enq_fgr),
        .i_enq_speculative (i_enq_speculative),
        .i_enq_valid       (i_enq_valid),
        .o_enq_ready       (o_enq_ready),
        .i_commit_fgr      (i_commit_fgr),
        .i_commit_valid    (i_commit_valid),
        .i_abandon_fgr     (i_abandon_fgr),
        .i_abandon_valid   (i_abandon_valid),
        .i_retire_valid    (i_retire_valid),
        .o_retire_ready    (o_retire_ready),
        .o_redeemed_prf    (o_redeemed_prf),
        .o_redeemed_valid  (o_redeemed_valid),
        .i_redeemed_ready  (i_redeemed_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] prf;
        logic [3:0] fgr;
        bit         spec;
        bit         live;
    } m_ent_t;

    m_ent_t     mq[$];
    bit         m_ov;
    logic [5:0] m_oprf;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov   = 1'b0;
        m_oprf = '0;
    endtask

    // One clock: drive at negedge, check outputs against the model, advance the model.
    task automatic cycle(input bit ev, input logic [5:0] ep, input logic [3:0] ef, input bit es,
                         input bit cv, input logic [3:0] cf, input bit av, input logic [3:0] af,
                         input bit rv, input bit rdy);
        bit     drop, ret, e_rdy, r_rdy;
        m_ent_t e;
        @(negedge clk);
        i_enq_valid = ev; i_enq_prf = ep; i_enq_fgr = ef; i_enq_speculative = es;
        i_commit_valid = cv; i_commit_fgr = cf; i_abandon_valid = av; i_abandon_fgr = af;
        i_retire_valid = rv; i_redeemed_ready = rdy;
        #1;
        drop  = (mq.size() > 0) && !mq[0].live;
        r_rdy = (mq.size() > 0) && mq[0].live && !mq[0].spec && (!m_ov || rdy);
        ret   = rv && r_rdy;
        e_rdy = (mq.size() < 16);
`ifdef ISSUE_RAT_REDEEMER_ENQ_BYPASS_EN
        e_rdy = e_rdy || drop || ret;
`endif
        check("enq_ready", {7'd0, o_enq_ready}, {7'd0, e_rdy});
        check("retire_ready", {7'd0, o_retire_ready}, {7'd0, r_rdy});
        check("redeemed_valid", {7'd0, o_redeemed_valid}, {7'd0, m_ov});
        if (m_ov) check("redeemed_prf", {2'd0, o_redeemed_prf}, {2'd0, m_oprf});
        if (ret) begin
            m_ov   = 1'b1;
            m_oprf = mq[0].prf;
        end else if (m_ov && rdy) begin
            m_ov = 1'b0;
        end
        if (drop || ret) void'(mq.pop_front());
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (cv && e.live && e.fgr == cf) e.spec = 1'b0;
            if (av && e.fgr == af) e.live = 1'b0;
            mq[i] = e;
        end
        if (ev && e_rdy) begin
            e.prf  = ep;
            e.fgr  = ef;
            e.spec = es && !(cv && cf == ef);
            e.live = !(av && af == ef);
            mq.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic enq(input logic [5:0] p, input logic [3:0] f, input bit s);
        cycle(1, p, f, s, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic idle(input bit rv, input bit rdy);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, rv, rdy);
    endtask

    initial begin
        reset = 1'b1;
        {i_enq_valid, i_enq_prf, i_enq_fgr, i_enq_speculative} = '0;
        {i_commit_valid, i_commit_fgr, i_abandon_valid, i_abandon_fgr} = '0;
        {i_retire_valid, i_redeemed_ready} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_enq_ready", {7'd0, o_enq_ready}, 8'd1);
        check("rst_retire_ready", {7'd0, o_retire_ready}, 8'd0);
        check("rst_redeemed_valid", {7'd0, o_redeemed_valid}, 8'd0);
        check("rst_redeemed_prf", {2'd0, o_redeemed_prf}, 8'd0);
        reset = 1'b0;

        // Simple retire with one-cycle latency
        enq(6'h21, 4'd3, 0);
        idle(1, 1);
        idle(0, 1);
        check("r060_prf", {2'd0, o_redeemed_prf}, 8'h21);
        idle(0, 1);

        // Speculative head waits for commit
        enq(6'h05, 4'd2, 1);
        idle(1, 1);
        cycle(0, 0, 0, 0, 1, 4'd2, 0, 0, 0, 1);
        idle(1, 1);
        idle(0, 1);

        // Abandoned head is dropped silently
        enq(6'h10, 4'd1, 1);
        enq(6'h11, 4'd0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 4'd1, 1, 1);
        idle(1, 1);
        idle(1, 1);
        idle(0, 1);

        // Fill, overflow attempt, then drain in order across the wrap
        for (int i = 0; i < 16; i++) enq(6'(8'h20 + i), 4'(i % 8), 0);
        enq(6'h3E, 4'd9, 0);
        idle(1, 1);
        enq(6'h30, 4'd9, 0);
        for (int i = 0; i < 17; i++) idle(1, 1);
        idle(0, 1);

        // Back-pressure on the redeem port
        for (int i = 0; i < 4; i++) enq(6'(8'h08 + i), 4'd4, 0);
        idle(1, 0);
        for (int i = 0; i < 5; i++) idle(1, 0);
        for (int i = 0; i < 5; i++) idle(1, 1);

        // Commit and abandon of the same FGR: abandon wins
        enq(6'h3F, 4'd7, 1);
        cycle(0, 0, 0, 0, 1, 4'd7, 1, 4'd7, 0, 1);
        for (int i = 0; i < 3; i++) idle(1, 1);

        // Reset while a redeem is pending
        enq(6'h2A, 4'd5, 0);
        idle(1, 0);
        idle(0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("r065_rst_valid", {7'd0, o_redeemed_valid}, 8'd0);
        check("r065_rst_prf", {2'd0, o_redeemed_prf}, 8'd0);
        check("r065_rst_enq_ready", {7'd0, o_enq_ready}, 8'd1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) idle(1, 1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            cycle($urandom_range(0, 9) < 6, 6'($urandom), 4'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3, 4'($urandom_range(0, 7)),
                  $urandom_range(0, 19) < 2, 4'($urandom_range(0, 7)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
